// File: rtl/arty_input_conditioner.sv
// Board-input front end: 2-FF sync, per-channel debounce with edge pulses and
// sticky rise events, plus a stretched, synchronously released system reset.
module arty_input_conditioner #(
  parameter int              N_IN            = 8,
  parameter int              CNT_W           = 20,
  parameter int              DEBOUNCE_CYCLES = 1000000,
  parameter logic [N_IN-1:0] INVERT_MASK     = '0,
  parameter int              RST_HOLD_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] in_i,
  input  logic [N_IN-1:0] event_clr_i,
  output logic [N_IN-1:0] level_o,
  output logic [N_IN-1:0] rise_o,
  output logic [N_IN-1:0] fall_o,
  output logic [N_IN-1:0] event_o,
  output logic            sys_rst_no
);

  localparam int                HOLD_W    = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);

  logic [N_IN-1:0]  r_sync1;
  logic [N_IN-1:0]  r_sync2;
  logic [N_IN-1:0]  r_level;
  logic [N_IN-1:0]  r_rise;
  logic [N_IN-1:0]  r_fall;
  logic [N_IN-1:0]  r_event;
  logic [CNT_W-1:0] r_cnt [N_IN];

  logic [N_IN-1:0]  w_s;
  logic [N_IN-1:0]  w_flip;
  logic [N_IN-1:0]  w_rise;
  logic [N_IN-1:0]  w_fall;
  logic [CNT_W-1:0] w_cnt_nxt [N_IN];

  logic              r_rst_meta;
  logic              r_rst_sync;
  logic [HOLD_W-1:0] r_hold;
  logic              r_sys_rst_n;

  // Sync flops reset to the polarity mask so the corrected level starts at 0.
  always_comb begin
    w_s = r_sync2 ^ INVERT_MASK;
    for (int i = 0; i < N_IN; i++) begin
      w_flip[i]    = (w_s[i] != r_level[i]) && (r_cnt[i] == DB_LAST);
      w_cnt_nxt[i] = ((w_s[i] == r_level[i]) || w_flip[i]) ? '0
                                                           : r_cnt[i] + CNT_W'(1);
    end
    w_rise = w_flip & ~r_level;
    w_fall = w_flip & r_level;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= INVERT_MASK;
      r_sync2 <= INVERT_MASK;
      r_level <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      r_event <= '0;
      for (int i = 0; i < N_IN; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= in_i;
      r_sync2 <= r_sync1;
      r_level <= r_level ^ w_flip;
      r_rise  <= w_rise;
      r_fall  <= w_fall;
      // A rise in the same cycle as a clear keeps the flag set.
      r_event <= (r_event & ~event_clr_i) | w_rise;
      for (int i = 0; i < N_IN; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_meta  <= 1'b0;
      r_rst_sync  <= 1'b0;
      r_hold      <= '0;
      r_sys_rst_n <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
      if (r_rst_sync && !r_sys_rst_n) begin
        if (r_hold == HOLD_LAST) begin
          r_sys_rst_n <= 1'b1;
        end else begin
          r_hold <= r_hold + HOLD_W'(1);
        end
      end
    end
  end

  assign level_o    = r_level;
  assign rise_o     = r_rise;
  assign fall_o     = r_fall;
  assign event_o    = r_event;
  assign sys_rst_no = r_sys_rst_n;

endmodule
